mem_slave_ctrl: RTL
===================

Name: mem_slave_ctrl

Overview:
Parametrised memory-side controller for a bus slave. It accepts single-beat read and write requests from the serial slave core, arbitrates them onto an internal synchronous RAM of configurable depth and read latency, and returns a one-cycle data-valid acknowledge. It adds address range checking with an error flag, a busy indication, and a display-data register that feeds the BCD display driver.

Parameters:
ADDRESS_WIDTH, 15, width of the request address from the slave core
DATA_WIDTH, 8, data word width
MEM_DEPTH, 4096, number of RAM words; valid addresses are 0..MEM_DEPTH-1; must be ≤ 2**ADDRESS_WIDTH
READ_LATENCY, 1, RAM read latency in cycles; legal values are 1 or 2
ERR_DATA, 8'hFF, value returned on rdata for an out-of-range read (DATA_WIDTH wide)

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
rd_req  input  1  one-cycle read request pulse; addr_in is valid in the same cycle
wr_req  input  1  one-cycle write request pulse; addr_in and wdata are valid in the same cycle
addr_in  input  ADDRESS_WIDTH  request address
wdata  input  DATA_WIDTH  write data
rdata  output  DATA_WIDTH  read data; held stable until the next read completes
data_valid  output  1  one-cycle completion pulse for both reads and writes
busy  output  1  high from the cycle after an accepted request until data_valid
err  output  1  one-cycle pulse coincident with data_valid when the address was ≥ MEM_DEPTH
disp_data  output  DATA_WIDTH  last word read or written (goes to the bi2bcd driver)

Behaviour:
- Reset (async, rstn=0): state=IDLE; rdata=0, data_valid=0, busy=0, err=0, disp_data=0; latency counter=0. RAM contents are not cleared.
- FSM states:
  - IDLE: waits for a request; busy=0.
  - WR: asserts RAM wren for exactly one cycle.
  - RD_WAIT: counts READ_LATENCY cycles.
  - DONE: data_valid=1 for one cycle, then returns to IDLE.
- Acceptance:
  - A request is accepted only in IDLE. addr_in and wdata are latched on the accepting edge.
  - Requests arriving while busy=1 are ignored: no queueing, no error.
- Simultaneous rd_req and wr_req in IDLE: the write wins and the read is dropped.
- Write, request in cycle 0:
  - cycle 1: WR, wren=1 with latched address and data; busy=1.
  - cycle 2: DONE, data_valid=1, disp_data=latched wdata.
  - Total latency is 2 cycles.
- Read, request in cycle 0:
  - cycles 1..READ_LATENCY: RD_WAIT with the RAM address driven.
  - cycle READ_LATENCY+1: DONE, data_valid=1; rdata and disp_data take the RAM output.
  - Latency is 2 cycles for READ_LATENCY=1 and 3 cycles for READ_LATENCY=2.
- Out-of-range address (latched address ≥ MEM_DEPTH):
  - Write: wren is never asserted. The FSM goes IDLE→DONE in one cycle; data_valid=1, err=1, disp_data unchanged.
  - Read: IDLE→DONE in one cycle; rdata=ERR_DATA, err=1, disp_data unchanged.
- RAM addressing: index = latched address truncated to clog2(MEM_DEPTH) bits, used only after the range check passes.
- Read-after-write: a read accepted the cycle after a write's DONE returns the new data. The RAM is write-first, and no bypass is needed because requests are serialised.
- Reset mid-operation: an in-flight write whose WR cycle has not yet occurred is lost. A write in WR at the reset edge has undefined completion. No data_valid is emitted after reset.
- data_valid and err are registered outputs with no combinational path from the inputs.

Decomposition:
- Shared package mem_slave_pkg holds:
  - FSM state encoding (IDLE, WR, RD_WAIT, DONE; 2-bit)
  - the default ERR_DATA constant
  - a clog2 function for RAM index width
- Sub-module: mem_slave_ram, a synchronous single-port write-first RAM parametrised by DATA_WIDTH, MEM_DEPTH and READ_LATENCY. READ_LATENCY=2 adds an output register.
- All sequencing lives in mem_slave_ctrl.

Test Plan:
- Write wr_req addr=0x0010 wdata=0x5A, then read addr=0x0010 → write data_valid 2 cycles after request, read data_valid 2 cycles after request with rdata=0x5A, disp_data=0x5A, err=0.
- READ_LATENCY=2: write 0x0FFF=0xC3, then read 0x0FFF → read data_valid exactly 3 cycles after rd_req, rdata=0xC3.
- Out-of-range with MEM_DEPTH=4096: write 0x1000=0x11, then read 0x1000 → each gives data_valid+err 1 cycle after the request; read rdata=0xFF; disp_data unchanged; read back of 0x0000 is unaffected.
- Same-cycle rd_req+wr_req addr=0x0020 wdata=0x77 → only a write is performed (one data_valid, rdata unchanged); subsequent read of 0x0020 returns 0x77.
- rd_req pulsed while busy=1 → ignored: exactly one data_valid for the first request, no err.
- rstn asserted during RD_WAIT → all outputs 0 immediately; no data_valid after release; earlier written data still readable.

Source files
------------

// File: rtl/mem_slave_pkg.sv
// Shared definitions for the memory-side slave controller: FSM encoding,
// default error read value and the RAM index width helper.
package mem_slave_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WR      = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [7:0] ERR_DATA_DEFAULT = 8'hFF;

    // Never returns less than 1 so a single-word RAM still gets a legal index.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((32'sd1 <<< w) < value) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_slave_ctrl_if.sv
// Request/response bundle between the serial slave core (master side)
// and the memory controller (slave side).
interface mem_slave_ctrl_if #(
    parameter int ADDRESS_WIDTH = 15,
    parameter int DATA_WIDTH    = 8
);
    logic                     rd_req;
    logic                     wr_req;
    logic [ADDRESS_WIDTH-1:0] addr_in;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [DATA_WIDTH-1:0]    rdata;
    logic                     data_valid;
    logic                     busy;
    logic                     err;
    logic [DATA_WIDTH-1:0]    disp_data;

    modport master (
        output rd_req, wr_req, addr_in, wdata,
        input  rdata, data_valid, busy, err, disp_data
    );

    modport slave (
        input  rd_req, wr_req, addr_in, wdata,
        output rdata, data_valid, busy, err, disp_data
    );
endinterface

// File: rtl/mem_slave_ram.sv
// Synchronous single-port write-first RAM; READ_LATENCY=2 adds one output
// register stage behind the array read register.
module mem_slave_ram #(
    parameter int DATA_WIDTH   = 8,
    parameter int MEM_DEPTH    = 4096,
    parameter int READ_LATENCY = 1,
    parameter int IDX_WIDTH    = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem_q  [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] pipe_q [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= din;
            pipe_q[0]   <= din;
        end else begin
            pipe_q[0]   <= mem_q[addr];
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign dout = pipe_q[READ_LATENCY-1];

endmodule

// File: rtl/mem_slave_ctrl.sv
// Memory-side controller: accepts one read or write at a time from the slave
// core, range-checks it, sequences the RAM and returns a one-cycle completion.
module mem_slave_ctrl
    import mem_slave_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 15,
    parameter int DATA_WIDTH    = 8,
    parameter int MEM_DEPTH     = 4096,
    parameter int READ_LATENCY  = 1,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERR_DATA_DEFAULT)
) (
    input  logic             clk,
    input  logic             rstn,
    mem_slave_ctrl_if.slave  bus
);

    localparam int IDX_W = clog2(MEM_DEPTH);
    localparam logic [ADDRESS_WIDTH:0] DEPTH_EXT = (ADDRESS_WIDTH+1)'(MEM_DEPTH);
    localparam logic [1:0] LAST_WAIT = 2'(READ_LATENCY - 1);

    logic [1:0]               state_q, state_d;
    logic [1:0]               cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     oor_q, oor_d;
    logic                     op_rd_q, op_rd_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]    disp_q, disp_d;
    logic                     dv_q, dv_d;
    logic                     busy_q, busy_d;
    logic                     err_q, err_d;

    logic                     addr_oor;
    logic                     ram_we;
    logic [DATA_WIDTH-1:0]    ram_dout;
    logic                     rd_done;

    assign addr_oor = {1'b0, bus.addr_in} >= DEPTH_EXT;
    assign ram_we   = (state_q == ST_WR);
    assign rd_done  = (state_q == ST_DONE) && op_rd_q && !oor_q;

    mem_slave_ram #(
        .DATA_WIDTH   (DATA_WIDTH),
        .MEM_DEPTH    (MEM_DEPTH),
        .READ_LATENCY (READ_LATENCY),
        .IDX_WIDTH    (IDX_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (addr_q[IDX_W-1:0]),
        .din  (wdata_q),
        .dout (ram_dout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        oor_d   = oor_q;
        op_rd_d = op_rd_q;
        rdata_d = rdata_q;
        disp_d  = disp_q;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.wr_req || bus.rd_req) begin
                    addr_d  = bus.addr_in;
                    wdata_d = bus.wdata;
                    oor_d   = addr_oor;
                    op_rd_d = !bus.wr_req;  // write wins a same-cycle collision
                    cnt_d   = 2'd0;
                    if (addr_oor) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                        if (!bus.wr_req) begin
                            rdata_d = ERR_DATA;
                        end
                    end else begin
                        state_d = bus.wr_req ? ST_WR : ST_RD_WAIT;
                    end
                end
            end
            ST_WR: begin
                state_d = ST_DONE;
                disp_d  = wdata_q;
            end
            ST_RD_WAIT: begin
                if (cnt_q == LAST_WAIT) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                // Freeze the RAM word so it stays on rdata after DONE.
                if (op_rd_q && !oor_q) begin
                    rdata_d = ram_dout;
                    disp_d  = ram_dout;
                end
            end
        endcase

        dv_d   = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            oor_q   <= 1'b0;
            op_rd_q <= 1'b0;
            rdata_q <= '0;
            disp_q  <= '0;
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            oor_q   <= oor_d;
            op_rd_q <= op_rd_d;
            rdata_q <= rdata_d;
            disp_q  <= disp_d;
            dv_q    <= dv_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // The RAM word only exists during DONE, so show it directly then.
    assign bus.rdata      = rd_done ? ram_dout : rdata_q;
    assign bus.disp_data  = rd_done ? ram_dout : disp_q;
    assign bus.data_valid = dv_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;

endmodule
